// File: rtl/sb_mem_responder.sv
// Memory responder with a 64-bit word array. It serves single reads and writes, critical-word-first
// read bursts and streamed write bursts. Every transaction is answered a fixed latency after accept.
module sb_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int BEATS   = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_in_req_ready,
  input  logic        io_in_req_valid,
  input  logic [31:0] io_in_req_bits_addr,
  input  logic [2:0]  io_in_req_bits_size,
  input  logic [3:0]  io_in_req_bits_cmd,
  input  logic [7:0]  io_in_req_bits_wmask,
  input  logic [63:0] io_in_req_bits_wdata,
  input  logic        io_in_resp_ready,
  output logic        io_in_resp_valid,
  output logic [3:0]  io_in_resp_bits_cmd,
  output logic [63:0] io_in_resp_bits_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BEATS);

  localparam logic [3:0] CMD_READ   = 4'b0000;
  localparam logic [3:0] CMD_WRITE  = 4'b0001;
  localparam logic [3:0] CMD_RBURST = 4'b0010;
  localparam logic [3:0] CMD_WBURST = 4'b0011;
  localparam logic [3:0] CMD_PROBE  = 4'b1000;
  localparam logic [3:0] RSP_BEAT   = 4'b0000;
  localparam logic [3:0] RSP_RLAST  = 4'b0110;
  localparam logic [3:0] RSP_WRITE  = 4'b0101;
  localparam logic [3:0] RSP_PMISS  = 4'b1000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, WBURST} state_t;
  typedef enum logic [1:0] {K_READ, K_BURST, K_WRITE, K_PROBE} kind_t;

  state_t        state, state_nxt;
  kind_t         kind, kind_nxt;
  logic [3:0]    lat_cnt, lat_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic [BW-1:0] beat, beat_nxt;
  logic          ready_en;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [AW-1:0] req_idx, req_wrap, idx_wrap;
  logic          req_fire, resp_fire, last_beat;
  logic          unused_bits;
  logic [63:0]   mem [DEPTH];

  // Word index and its in-line successor; burst addressing wraps inside a BEATS-word line
  assign req_idx   = io_in_req_bits_addr[AW+2:3];
  assign req_wrap  = {req_idx[AW-1:BW], req_idx[BW-1:0] + BW'(1)};
  assign idx_wrap  = {idx[AW-1:BW], idx[BW-1:0] + BW'(1)};
  assign unused_bits = ^{io_in_req_bits_size, io_in_req_bits_addr[31:AW+3], io_in_req_bits_addr[2:0]};

  assign io_in_req_ready  = ready_en && (state == IDLE || state == WBURST);
  assign io_in_resp_valid = (state == RESP);
  assign req_fire  = io_in_req_valid && io_in_req_ready;
  assign resp_fire = io_in_resp_valid && io_in_resp_ready;
  assign last_beat = (kind != K_BURST) || (beat == BW'(BEATS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      kind     <= K_READ;
      lat_cnt  <= 4'd0;
      idx      <= '0;
      beat     <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      lat_cnt  <= lat_nxt;
      idx      <= idx_nxt;
      beat     <= beat_nxt;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    lat_nxt   = lat_cnt;
    idx_nxt   = idx;
    beat_nxt  = beat;
    mem_we    = 1'b0;
    mem_widx  = idx;
    case (state)
      IDLE: begin
        if (req_fire) begin
          state_nxt = WAIT;
          lat_nxt   = 4'(LATENCY - 1);
          idx_nxt   = req_idx;
          beat_nxt  = '0;
          case (io_in_req_bits_cmd)
            CMD_READ:   kind_nxt = K_READ;
            CMD_RBURST: kind_nxt = K_BURST;
            CMD_PROBE:  kind_nxt = K_PROBE;
            CMD_WRITE: begin
              kind_nxt = K_WRITE;
              mem_we   = 1'b1;
              mem_widx = req_idx;
            end
            CMD_WBURST: begin
              state_nxt = WBURST;
              kind_nxt  = K_WRITE;
              mem_we    = 1'b1;
              mem_widx  = req_idx;
              idx_nxt   = req_wrap;
            end
            default: kind_nxt = K_WRITE;
          endcase
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) state_nxt = RESP;
        else                 lat_nxt   = lat_cnt - 4'd1;
      end
      RESP: begin
        if (resp_fire) begin
          if (last_beat) begin
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + BW'(1);
            idx_nxt  = idx_wrap;
          end
        end
      end
      WBURST: begin
        // Any command other than writeBurst closes the burst, but its data is still written
        if (req_fire) begin
          mem_we  = 1'b1;
          idx_nxt = idx_wrap;
          if (io_in_req_bits_cmd != CMD_WBURST) begin
            state_nxt = WAIT;
            kind_nxt  = K_WRITE;
            lat_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we)
      for (int b = 0; b < 8; b++)
        if (io_in_req_bits_wmask[b]) mem[mem_widx][b*8 +: 8] <= io_in_req_bits_wdata[b*8 +: 8];
  end

  always_comb begin
    io_in_resp_bits_cmd   = RSP_BEAT;
    io_in_resp_bits_rdata = '0;
    if (state == RESP) begin
      case (kind)
        K_READ: begin
          io_in_resp_bits_cmd   = RSP_RLAST;
          io_in_resp_bits_rdata = mem[idx];
        end
        K_BURST: begin
          io_in_resp_bits_cmd   = last_beat ? RSP_RLAST : RSP_BEAT;
          io_in_resp_bits_rdata = mem[idx];
        end
        K_WRITE: io_in_resp_bits_cmd = RSP_WRITE;
        default: io_in_resp_bits_cmd = RSP_PMISS;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_mem_responder.sv
// Randomised self-checking bench for sb_mem_responder against a plain word-array memory model.
module tb_sb_mem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int BEATS   = 8;
  localparam int AW      = $clog2(DEPTH);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_ready;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [3:0]  req_cmd = '0;
  logic [7:0]  req_wmask = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b1;
  logic        resp_valid;
  logic [3:0]  resp_cmd;
  logic [63:0] resp_rdata;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [63:0] model [DEPTH];

  sb_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BEATS(BEATS)) dut (
    .clock(clock), .reset(reset),
    .io_in_req_ready(req_ready), .io_in_req_valid(req_valid),
    .io_in_req_bits_addr(req_addr), .io_in_req_bits_size(req_size),
    .io_in_req_bits_cmd(req_cmd), .io_in_req_bits_wmask(req_wmask),
    .io_in_req_bits_wdata(req_wdata), .io_in_resp_ready(resp_ready),
    .io_in_resp_valid(resp_valid), .io_in_resp_bits_cmd(resp_cmd),
    .io_in_resp_bits_rdata(resp_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 3) % DEPTH;
  endfunction

  // Word returned by beat i of a burst: same line, offset rotated from the requested word
  function automatic int unsigned burst_word(input logic [31:0] a, input int i);
    int unsigned w;
    w = widx(a);
    return (w - w % BEATS) + ((w % BEATS + i) % BEATS);
  endfunction

  function automatic logic [3:0] exp_single_cmd(input logic [3:0] c);
    case (c)
      4'b0000: return 4'b0110;
      4'b1000: return 4'b1000;
      default: return 4'b0101;
    endcase
  endfunction

  task automatic model_write(input int unsigned w, input logic [7:0] m, input logic [63:0] d);
    for (int b = 0; b < 8; b++) if (m[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic send_req(input logic [3:0] c, input logic [31:0] a, input logic [7:0] m,
                          input logic [63:0] d, output int acc, output bit ok);
    req_cmd = c; req_addr = a; req_wmask = m; req_wdata = d; req_size = 3'($urandom);
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clock); #1; end
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic recv_beat(input bit stall, output logic [3:0] c, output logic [63:0] d,
                           output int at, output bit held, output bit ok);
    ok = 1'b0; held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    c = resp_cmd; d = resp_rdata; at = cyc;
    if (!ok) return;
    if (stall) begin
      @(posedge clock); #1;
      @(negedge clock);
      held = resp_valid && (resp_cmd === c) && (resp_rdata === d);
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
    end else begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_cmd !== 4'd0 || resp_rdata !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b cmd=%b rdata=%h, expected all 0",
               req_ready, resp_valid, resp_cmd, resp_rdata);
    end
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b1; #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ready_before_clock: got %b, expected 0", req_ready);
    end
    @(posedge clock); #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ready_after_clock: got %b, expected 1", req_ready);
    end
  endtask

  task automatic test_fill();
    logic [31:0] a; logic [63:0] d, rd; logic [3:0] rc; int acc, at; bit ok, held;
    resp_ready = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      a = $urandom; a[AW+2:3] = AW'(w); d = {$urandom, $urandom};
      send_req(4'b0001, a, 8'hFF, d, acc, ok);
      model_write(w, 8'hFF, d);
      recv_beat(1'b0, rc, rd, at, held, ok);
      tests_run++;
      if (!ok || rc !== 4'b0101 || rd !== 64'd0 || at - acc != LATENCY) begin
        tests_failed++;
        $display("[TB] FAIL fill_write w=%0d: got cmd=%b rdata=%h lat=%0d, expected cmd=0101 rdata=0 lat=%0d",
                 w, rc, rd, at - acc, LATENCY);
        break;
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0] rc; logic [63:0] rd; int acc, at; bit ok, held;
    resp_ready = 1'b1;
    send_req(4'b0001, 32'h40, 8'hFF, 64'h1122334455667788, acc, ok);
    model_write(widx(32'h40), 8'hFF, 64'h1122334455667788);
    recv_beat(1'b0, rc, rd, at, held, ok);
    tests_run++;
    if (!ok || rc !== 4'b0101 || rd !== 64'd0 || at - acc != LATENCY) begin
      tests_failed++;
      $display("[TB] FAIL dir_write: got cmd=%b rdata=%h lat=%0d, expected 0101 0 %0d", rc, rd, at - acc, LATENCY);
    end
    send_req(4'b0000, 32'h40, 8'h00, 64'd0, acc, ok);
    recv_beat(1'b0, rc, rd, at, held, ok);
    tests_run++;
    if (!ok || rc !== 4'b0110 || rd !== 64'h1122334455667788 || at - acc != LATENCY) begin
      tests_failed++;
      $display("[TB] FAIL dir_read: got cmd=%b rdata=%h lat=%0d, expected 0110 1122334455667788 %0d",
               rc, rd, at - acc, LATENCY);
    end
    send_req(4'b0001, 32'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA, acc, ok);
    model_write(widx(32'h40), 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    recv_beat(1'b0, rc, rd, at, held, ok);
    send_req(4'b0000, 32'h40, 8'h00, 64'd0, acc, ok);
    recv_beat(1'b0, rc, rd, at, held, ok);
    tests_run++;
    if (!ok || rc !== 4'b0110 || rd !== 64'h11223344AAAAAAAA) begin
      tests_failed++;
      $display("[TB] FAIL dir_masked_read: got cmd=%b rdata=%h, expected 0110 11223344aaaaaaaa", rc, rd);
    end
  endtask

  task automatic test_read_burst(input bit stall);
    int unsigned order [8];
    logic [3:0] rc; logic [63:0] rd; int acc, at, first; bit ok, held;
    order = '{5, 6, 7, 0, 1, 2, 3, 4};
    resp_ready = !stall;
    send_req(4'b0010, 32'h28, 8'h00, 64'd0, acc, ok);
    first = acc + LATENCY;
    for (int i = 0; i < BEATS; i++) begin
      recv_beat(stall, rc, rd, at, held, ok);
      tests_run++;
      if (!ok || !held || rc !== (i == BEATS - 1 ? 4'b0110 : 4'b0000) || rd !== model[order[i]] ||
          at != first + (stall ? 2 * i : i)) begin
        tests_failed++;
        $display("[TB] FAIL burst_beat stall=%0d i=%0d: got cmd=%b rdata=%h cyc=%0d held=%0d, expected rdata=%h cyc=%0d held=1",
                 stall, i, rc, rd, at, held, model[order[i]], first + (stall ? 2 * i : i));
        break;
      end
    end
    resp_ready = 1'b1;
  endtask

  task automatic test_write_burst();
    logic [63:0] wd [BEATS];
    logic [3:0] rc, c; logic [63:0] rd; logic [31:0] a; logic [7:0] m;
    int acc, at; bit ok, held; int unsigned s, base, nb;
    resp_ready = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      wd[i] = {$urandom, $urandom};
      send_req(i == BEATS - 1 ? 4'b0111 : 4'b0011, i == 0 ? 32'h0 : $urandom, 8'hFF, wd[i], acc, ok);
      model_write(i, 8'hFF, wd[i]);
      tests_run++;
      if (!ok) begin tests_failed++; $display("[TB] FAIL wburst_accept i=%0d: got no ready, expected ready", i); end
    end
    recv_beat(1'b0, rc, rd, at, held, ok);
    tests_run++;
    if (!ok || rc !== 4'b0101 || rd !== 64'd0 || at - acc != LATENCY) begin
      tests_failed++;
      $display("[TB] FAIL wburst_resp: got cmd=%b rdata=%h lat=%0d, expected 0101 0 %0d", rc, rd, at - acc, LATENCY);
    end
    send_req(4'b0010, 32'h0, 8'h00, 64'd0, acc, ok);
    for (int i = 0; i < BEATS; i++) begin
      recv_beat(1'b0, rc, rd, at, held, ok);
      tests_run++;
      if (!ok || rd !== wd[i]) begin
        tests_failed++; $display("[TB] FAIL wburst_readback i=%0d: got %h, expected %h", i, rd, wd[i]);
        break;
      end
    end
    // Mid-line start with random masks, closed early by an arbitrary non-writeBurst command
    for (int n = 0; n < 6; n++) begin
      a = $urandom; s = widx(a) % BEATS; base = widx(a) - s;
      nb = $urandom_range(1, BEATS - 1);
      for (int i = 0; i <= nb; i++) begin
        m = 8'($urandom);
        if (i == nb) begin do c = 4'($urandom); while (c == 4'b0011); end
        else c = 4'b0011;
        wd[0] = {$urandom, $urandom};
        send_req(c, i == 0 ? a : $urandom, m, wd[0], acc, ok);
        model_write(base + (s + i) % BEATS, m, wd[0]);
      end
      recv_beat(1'b0, rc, rd, at, held, ok);
      tests_run++;
      if (!ok || rc !== 4'b0101 || at - acc != LATENCY) begin
        tests_failed++;
        $display("[TB] FAIL wburst_term_resp: got cmd=%b lat=%0d, expected 0101 %0d", rc, at - acc, LATENCY);
      end
      send_req(4'b0010, a, 8'h00, 64'd0, acc, ok);
      for (int i = 0; i < BEATS; i++) begin
        recv_beat(1'b0, rc, rd, at, held, ok);
        tests_run++;
        if (!ok || rd !== model[burst_word(a, i)]) begin
          tests_failed++;
          $display("[TB] FAIL wburst_term_read i=%0d: got %h, expected %h", i, rd, model[burst_word(a, i)]);
          break;
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] c, rc; logic [31:0] a; logic [7:0] m; logic [63:0] d, rd, expd;
    int acc, at, first; bit ok, held, stall; int unsigned sel, w;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      a = $urandom; m = 8'($urandom); d = {$urandom, $urandom}; stall = 1'($urandom);
      if (sel <= 2) c = 4'b0000;
      else if (sel <= 5) c = 4'b0001;
      else if (sel == 6) c = 4'b1000;
      else if (sel == 7) begin
        do c = 4'($urandom); while (c inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000});
      end else c = 4'b0010;
      w = widx(a);
      resp_ready = !stall;
      send_req(c, a, m, d, acc, ok);
      if (c == 4'b0001) model_write(w, m, d);
      if (c == 4'b0010) begin
        first = acc + LATENCY;
        for (int i = 0; i < BEATS; i++) begin
          recv_beat(stall, rc, rd, at, held, ok);
          expd = model[burst_word(a, i)];
          tests_run++;
          if (!ok || !held || rc !== (i == BEATS - 1 ? 4'b0110 : 4'b0000) || rd !== expd ||
              at != first + (stall ? 2 * i : i)) begin
            tests_failed++;
            $display("[TB] FAIL rand_burst n=%0d i=%0d: got cmd=%b rdata=%h cyc=%0d held=%0d, expected rdata=%h cyc=%0d",
                     n, i, rc, rd, at, held, expd, first + (stall ? 2 * i : i));
            break;
          end
        end
      end else begin
        recv_beat(stall, rc, rd, at, held, ok);
        expd = (c == 4'b0000) ? model[w] : 64'd0;
        tests_run++;
        if (!ok || !held || rc !== exp_single_cmd(c) || rd !== expd || at - acc != LATENCY) begin
          tests_failed++;
          $display("[TB] FAIL rand_single n=%0d cmd=%b: got rcmd=%b rdata=%h lat=%0d held=%0d, expected rcmd=%b rdata=%h lat=%0d",
                   n, c, rc, rd, at - acc, held, exp_single_cmd(c), expd, LATENCY);
        end
      end
    end
    resp_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b; logic [3:0] rc; logic [63:0] rd; int acc, at; bit ok, held;
    resp_ready = 1'b1;
    a = $urandom; b = $urandom;
    send_req(4'b0000, a, 8'h00, 64'd0, acc, ok);
    req_cmd = 4'b0000; req_addr = b; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (!ok || req_ready !== 1'b0 || resp_rdata !== model[widx(a)]) begin
      tests_failed++;
      $display("[TB] FAIL b2b_final_beat: got valid=%b ready=%b rdata=%h, expected 1 0 %h",
               ok, req_ready, resp_rdata, model[widx(a)]);
    end
    @(posedge clock); #1;
    @(negedge clock);
    tests_run++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle: got valid=%b ready=%b, expected valid=0 ready=1", resp_valid, req_ready);
    end
    @(posedge clock); #1;
    acc = cyc; req_valid = 1'b0;
    recv_beat(1'b0, rc, rd, at, held, ok);
    tests_run++;
    if (!ok || rc !== 4'b0110 || rd !== model[widx(b)] || at - acc != LATENCY) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got cmd=%b rdata=%h lat=%0d, expected 0110 %h %0d",
               rc, rd, at - acc, model[widx(b)], LATENCY);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a; logic [3:0] rc; logic [63:0] rd; int acc, at; bit ok, held;
    resp_ready = 1'b1;
    a = $urandom;
    send_req(4'b0010, a, 8'h00, 64'd0, acc, ok);
    for (int i = 0; i < 4; i++) recv_beat(1'b0, rc, rd, at, held, ok);
    reset = 1'b0; #1;
    tests_run++;
    if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_cmd !== 4'd0 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midburst_reset: got valid=%b rdata=%h cmd=%b ready=%b, expected all 0",
               resp_valid, resp_rdata, resp_cmd, req_ready);
    end
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    send_req(4'b0010, a, 8'h00, 64'd0, acc, ok);
    for (int i = 0; i < BEATS; i++) begin
      recv_beat(1'b0, rc, rd, at, held, ok);
      tests_run++;
      if (!ok || rd !== model[burst_word(a, i)]) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_read i=%0d: got %h, expected %h", i, rd, model[burst_word(a, i)]);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_read_burst(1'b0);
    test_read_burst(1'b1);
    test_write_burst();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
